// File: rtl/ftdi_245fifo_dev_model.sv
// Device-side FT60x 245 synchronous FIFO responder with AXIS host ports.
// Serves as a loopback target for the FPGA-side 245 FIFO driver.
module ftdi_245fifo_dev_model #(
  parameter int FIFO_BUS_WIDTH = 2,
  parameter int DN_DEPTH       = 16,
  parameter int UP_DEPTH       = 16,
  parameter int TXE_MARGIN     = 2
) (
  input  logic                          usb_clk,
  input  logic                          rstn_usbclk,
  output logic                          usb_txe_n,
  output logic                          usb_rxf_n,
  input  logic                          usb_wr_n,
  input  logic                          usb_rd_n,
  input  logic                          usb_oe_n,
  input  logic [FIFO_BUS_WIDTH-1:0]     usb_be_i,
  input  logic [8*FIFO_BUS_WIDTH-1:0]   usb_data_i,
  output logic [FIFO_BUS_WIDTH-1:0]     usb_be_o,
  output logic                          usb_be_t,
  output logic [8*FIFO_BUS_WIDTH-1:0]   usb_data_o,
  output logic                          usb_data_t,
  input  logic [8*FIFO_BUS_WIDTH-1:0]   h_s_tdata,
  input  logic [FIFO_BUS_WIDTH-1:0]     h_s_tkeep,
  input  logic                          h_s_tvalid,
  output logic                          h_s_tready,
  output logic [8*FIFO_BUS_WIDTH-1:0]   h_m_tdata,
  output logic [FIFO_BUS_WIDTH-1:0]     h_m_tkeep,
  output logic                          h_m_tvalid,
  input  logic                          h_m_tready,
  input  logic                          clr_err,
  output logic                          wr_overflow,
  output logic                          rd_underflow,
  output logic                          proto_err
);
  localparam int DW  = 8 * FIFO_BUS_WIDTH;
  localparam int EW  = DW + FIFO_BUS_WIDTH;
  localparam int DAW = $clog2(DN_DEPTH);
  localparam int DCW = DAW + 1;
  localparam int UAW = $clog2(UP_DEPTH);
  localparam int UCW = UAW + 1;
  localparam logic [DCW-1:0] DN_FULL   = DCW'(DN_DEPTH);
  localparam logic [UCW-1:0] UP_FULL   = UCW'(UP_DEPTH);
  localparam logic [UCW-1:0] UP_MARGIN = UCW'(TXE_MARGIN);

  logic [EW-1:0]  dn_mem [DN_DEPTH];
  logic [EW-1:0]  up_mem [UP_DEPTH];

  logic [DAW-1:0] dn_wr_ptr_q, dn_wr_ptr_d, dn_rd_ptr_q, dn_rd_ptr_d;
  logic [DCW-1:0] dn_count_q, dn_count_d;
  logic [UAW-1:0] up_wr_ptr_q, up_wr_ptr_d, up_rd_ptr_q, up_rd_ptr_d;
  logic [UCW-1:0] up_count_q, up_count_d;
  logic           h_s_tready_q, h_s_tready_d;
  logic           usb_txe_n_q, usb_txe_n_d;
  logic           usb_rxf_n_q, usb_rxf_n_d;
  logic           usb_data_t_q, usb_data_t_d;
  logic           usb_be_t_q, usb_be_t_d;
  logic [DW-1:0]  usb_data_o_q, usb_data_o_d;
  logic [FIFO_BUS_WIDTH-1:0] usb_be_o_q, usb_be_o_d;
  logic           wr_overflow_q, wr_overflow_d;
  logic           rd_underflow_q, rd_underflow_d;
  logic           proto_err_q, proto_err_d;

  logic           wr_req_s, rd_req_s, oe_req_s;
  logic           proto_evt_s, underflow_evt_s, overflow_evt_s;
  logic           dn_push_s, dn_pop_s, up_wr_ok_s, up_push_s, up_pop_s;
  logic [DCW-1:0] dn_after_pop_s;
  logic [EW-1:0]  dn_head_s, up_head_s;

  // Bus decode, buffer bookkeeping and next-state of every registered output
  always_comb begin
    wr_req_s        = ~usb_wr_n;
    rd_req_s        = ~usb_rd_n;
    oe_req_s        = ~usb_oe_n;
    proto_evt_s     = (wr_req_s & oe_req_s) | (rd_req_s & ~oe_req_s) | (wr_req_s & rd_req_s);
    underflow_evt_s = rd_req_s & oe_req_s & (dn_count_q == {DCW{1'b0}});

    dn_push_s  = h_s_tvalid & h_s_tready_q & (|h_s_tkeep);
    dn_pop_s   = rd_req_s & oe_req_s & ~wr_req_s & (dn_count_q != {DCW{1'b0}});
    up_wr_ok_s = wr_req_s & ~oe_req_s & ~rd_req_s & (|usb_be_i);
    up_push_s  = up_wr_ok_s & (up_count_q != UP_FULL);
    overflow_evt_s = up_wr_ok_s & (up_count_q == UP_FULL);
    up_pop_s   = (up_count_q != {UCW{1'b0}}) & h_m_tready;

    dn_wr_ptr_d    = dn_wr_ptr_q + DAW'(dn_push_s);
    dn_rd_ptr_d    = dn_rd_ptr_q + DAW'(dn_pop_s);
    dn_after_pop_s = dn_count_q - DCW'(dn_pop_s);
    dn_count_d     = dn_after_pop_s + DCW'(dn_push_s);
    up_wr_ptr_d    = up_wr_ptr_q + UAW'(up_push_s);
    up_rd_ptr_d    = up_rd_ptr_q + UAW'(up_pop_s);
    up_count_d     = up_count_q - UCW'(up_pop_s) + UCW'(up_push_s);

    // An empty buffer refilled this cycle has its head still on the input bus
    if (dn_after_pop_s == {DCW{1'b0}}) begin
      dn_head_s = {h_s_tkeep, h_s_tdata};
    end else begin
      dn_head_s = dn_mem[dn_rd_ptr_d];
    end

    h_s_tready_d = (dn_count_d != DN_FULL);
    usb_rxf_n_d  = (dn_count_d == {DCW{1'b0}});
    usb_txe_n_d  = ((UP_FULL - up_count_d) <= UP_MARGIN);
    usb_data_t_d = usb_oe_n;
    usb_be_t_d   = usb_oe_n;

    if (oe_req_s && (dn_count_d != {DCW{1'b0}})) begin
      usb_be_o_d   = dn_head_s[EW-1:DW];
      usb_data_o_d = dn_head_s[DW-1:0];
    end else begin
      usb_be_o_d   = {FIFO_BUS_WIDTH{1'b0}};
      usb_data_o_d = usb_data_o_q;
    end

    wr_overflow_d  = overflow_evt_s  | (wr_overflow_q  & ~clr_err);
    rd_underflow_d = underflow_evt_s | (rd_underflow_q & ~clr_err);
    proto_err_d    = proto_evt_s     | (proto_err_q    & ~clr_err);
  end

  // Control and output registers; reset empties both buffers
  always_ff @(posedge usb_clk or negedge rstn_usbclk) begin
    if (!rstn_usbclk) begin
      dn_wr_ptr_q    <= {DAW{1'b0}};
      dn_rd_ptr_q    <= {DAW{1'b0}};
      dn_count_q     <= {DCW{1'b0}};
      up_wr_ptr_q    <= {UAW{1'b0}};
      up_rd_ptr_q    <= {UAW{1'b0}};
      up_count_q     <= {UCW{1'b0}};
      h_s_tready_q   <= 1'b0;
      usb_txe_n_q    <= 1'b1;
      usb_rxf_n_q    <= 1'b1;
      usb_data_t_q   <= 1'b1;
      usb_be_t_q     <= 1'b1;
      usb_data_o_q   <= {DW{1'b0}};
      usb_be_o_q     <= {FIFO_BUS_WIDTH{1'b0}};
      wr_overflow_q  <= 1'b0;
      rd_underflow_q <= 1'b0;
      proto_err_q    <= 1'b0;
    end else begin
      dn_wr_ptr_q    <= dn_wr_ptr_d;
      dn_rd_ptr_q    <= dn_rd_ptr_d;
      dn_count_q     <= dn_count_d;
      up_wr_ptr_q    <= up_wr_ptr_d;
      up_rd_ptr_q    <= up_rd_ptr_d;
      up_count_q     <= up_count_d;
      h_s_tready_q   <= h_s_tready_d;
      usb_txe_n_q    <= usb_txe_n_d;
      usb_rxf_n_q    <= usb_rxf_n_d;
      usb_data_t_q   <= usb_data_t_d;
      usb_be_t_q     <= usb_be_t_d;
      usb_data_o_q   <= usb_data_o_d;
      usb_be_o_q     <= usb_be_o_d;
      wr_overflow_q  <= wr_overflow_d;
      rd_underflow_q <= rd_underflow_d;
      proto_err_q    <= proto_err_d;
    end
  end

  // Buffer storage needs no reset: validity is carried by the counts
  always_ff @(posedge usb_clk) begin
    if (dn_push_s) begin
      dn_mem[dn_wr_ptr_q] <= {h_s_tkeep, h_s_tdata};
    end
    if (up_push_s) begin
      up_mem[up_wr_ptr_q] <= {usb_be_i, usb_data_i};
    end
  end

  assign up_head_s    = up_mem[up_rd_ptr_q];
  assign h_m_tdata    = up_head_s[DW-1:0];
  assign h_m_tkeep    = up_head_s[EW-1:DW];
  assign h_m_tvalid   = (up_count_q != {UCW{1'b0}});
  assign h_s_tready   = h_s_tready_q;
  assign usb_txe_n    = usb_txe_n_q;
  assign usb_rxf_n    = usb_rxf_n_q;
  assign usb_data_t   = usb_data_t_q;
  assign usb_be_t     = usb_be_t_q;
  assign usb_data_o   = usb_data_o_q;
  assign usb_be_o     = usb_be_o_q;
  assign wr_overflow  = wr_overflow_q;
  assign rd_underflow = rd_underflow_q;
  assign proto_err    = proto_err_q;

endmodule

// File: tb/tb_ftdi_245fifo_dev_model.sv
// Randomised bench for ftdi_245fifo_dev_model, checked against a queue-based
// model of both buffers and of the bus rules.
module tb_ftdi_245fifo_dev_model;
  localparam int BW = 2, DW = 16, DN_DEPTH = 16, UP_DEPTH = 16, TXE_MARGIN = 2;

  logic usb_clk = 1'b0, rstn_usbclk = 1'b0;
  logic usb_txe_n, usb_rxf_n, usb_wr_n, usb_rd_n, usb_oe_n;
  logic [BW-1:0] usb_be_i, usb_be_o, h_s_tkeep, h_m_tkeep;
  logic [DW-1:0] usb_data_i, usb_data_o, h_s_tdata, h_m_tdata;
  logic usb_be_t, usb_data_t, h_s_tvalid, h_s_tready, h_m_tvalid, h_m_tready;
  logic clr_err, wr_overflow, rd_underflow, proto_err;

  int n_cmp = 0, n_err = 0;

  logic [BW+DW-1:0] dn_q[$], up_q[$];
  logic exp_tready, exp_txe_n, exp_rxf_n, exp_data_t, exp_be_t;
  logic exp_ovf, exp_unf, exp_proto;
  logic [DW-1:0] exp_data_o;
  logic [BW-1:0] exp_be_o;

  ftdi_245fifo_dev_model #(.FIFO_BUS_WIDTH(BW), .DN_DEPTH(DN_DEPTH),
                           .UP_DEPTH(UP_DEPTH), .TXE_MARGIN(TXE_MARGIN)) dut (
    .usb_clk(usb_clk), .rstn_usbclk(rstn_usbclk),
    .usb_txe_n(usb_txe_n), .usb_rxf_n(usb_rxf_n),
    .usb_wr_n(usb_wr_n), .usb_rd_n(usb_rd_n), .usb_oe_n(usb_oe_n),
    .usb_be_i(usb_be_i), .usb_data_i(usb_data_i),
    .usb_be_o(usb_be_o), .usb_be_t(usb_be_t),
    .usb_data_o(usb_data_o), .usb_data_t(usb_data_t),
    .h_s_tdata(h_s_tdata), .h_s_tkeep(h_s_tkeep), .h_s_tvalid(h_s_tvalid),
    .h_s_tready(h_s_tready),
    .h_m_tdata(h_m_tdata), .h_m_tkeep(h_m_tkeep), .h_m_tvalid(h_m_tvalid),
    .h_m_tready(h_m_tready),
    .clr_err(clr_err), .wr_overflow(wr_overflow),
    .rd_underflow(rd_underflow), .proto_err(proto_err)
  );

  initial forever #5 usb_clk = ~usb_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    dn_q.delete();
    up_q.delete();
    exp_tready = 1'b0; exp_txe_n = 1'b1; exp_rxf_n = 1'b1;
    exp_data_t = 1'b1; exp_be_t = 1'b1;
    exp_data_o = 16'h0000; exp_be_o = 2'b00;
    exp_ovf = 1'b0; exp_unf = 1'b0; exp_proto = 1'b0;
  endtask

  // Apply one clock of bus rules to the queues, using the current inputs
  task automatic model_step();
    logic wr, rd, oe, proto, unf, ovf, pop_dn, push_dn, up_ok, push_up, pop_up;
    wr = !usb_wr_n; rd = !usb_rd_n; oe = !usb_oe_n;
    proto   = (wr && oe) || (rd && !oe) || (wr && rd);
    unf     = rd && oe && (dn_q.size() == 0);
    pop_dn  = rd && oe && !wr && (dn_q.size() != 0);
    push_dn = h_s_tvalid && exp_tready && (h_s_tkeep != 2'b00);
    up_ok   = wr && !oe && !rd && (usb_be_i != 2'b00);
    push_up = up_ok && (up_q.size() < UP_DEPTH);
    ovf     = up_ok && (up_q.size() == UP_DEPTH);
    pop_up  = (up_q.size() != 0) && h_m_tready;
    if (pop_dn) void'(dn_q.pop_front());
    if (push_dn) dn_q.push_back({h_s_tkeep, h_s_tdata});
    if (pop_up) void'(up_q.pop_front());
    if (push_up) up_q.push_back({usb_be_i, usb_data_i});
    exp_tready = dn_q.size() < DN_DEPTH;
    exp_rxf_n  = dn_q.size() == 0;
    exp_txe_n  = (UP_DEPTH - up_q.size()) <= TXE_MARGIN;
    exp_data_t = usb_oe_n;
    exp_be_t   = usb_oe_n;
    if (oe && dn_q.size() != 0) begin
      exp_be_o   = dn_q[0][BW+DW-1:DW];
      exp_data_o = dn_q[0][DW-1:0];
    end else begin
      exp_be_o = 2'b00;
    end
    exp_ovf   = ovf   || (exp_ovf   && !clr_err);
    exp_unf   = unf   || (exp_unf   && !clr_err);
    exp_proto = proto || (exp_proto && !clr_err);
  endtask

  task automatic check_regs();
    chk("h_s_tready", 32'(h_s_tready), 32'(exp_tready));
    chk("usb_txe_n", 32'(usb_txe_n), 32'(exp_txe_n));
    chk("usb_rxf_n", 32'(usb_rxf_n), 32'(exp_rxf_n));
    chk("usb_data_t", 32'(usb_data_t), 32'(exp_data_t));
    chk("usb_be_t", 32'(usb_be_t), 32'(exp_be_t));
    chk("usb_be_o", 32'(usb_be_o), 32'(exp_be_o));
    chk("usb_data_o", 32'(usb_data_o), 32'(exp_data_o));
    chk("wr_overflow", 32'(wr_overflow), 32'(exp_ovf));
    chk("rd_underflow", 32'(rd_underflow), 32'(exp_unf));
    chk("proto_err", 32'(proto_err), 32'(exp_proto));
  endtask

  // One clock: check the FWFT head, advance model and DUT, check registers
  task automatic step();
    chk("h_m_tvalid", 32'(h_m_tvalid), 32'(up_q.size() != 0));
    if (up_q.size() != 0) chk("h_m_head", 32'({h_m_tkeep, h_m_tdata}), 32'(up_q[0]));
    model_step();
    @(posedge usb_clk);
    #1;
    check_regs();
  endtask

  task automatic idle_inputs();
    usb_wr_n = 1'b1; usb_rd_n = 1'b1; usb_oe_n = 1'b1;
    usb_be_i = 2'b00; usb_data_i = 16'h0000;
    h_s_tdata = 16'h0000; h_s_tkeep = 2'b00; h_s_tvalid = 1'b0;
    h_m_tready = 1'b0; clr_err = 1'b0;
  endtask

  initial begin
    idle_inputs();
    model_reset();
    repeat (3) @(posedge usb_clk);
    #1;
    check_regs();
    chk("reset_h_m_tvalid", 32'(h_m_tvalid), 32'h0);
    rstn_usbclk = 1'b1;
    step();
    chk("tready_after_release", 32'(h_s_tready), 32'h1);

    // Host loads 1..4, FPGA reads them back
    for (int i = 1; i <= 4; i++) begin
      h_s_tvalid = 1'b1; h_s_tkeep = 2'b11; h_s_tdata = 16'(i);
      step();
    end
    h_s_tvalid = 1'b0;
    usb_oe_n = 1'b0;
    step();
    for (int i = 1; i <= 4; i++) begin
      chk("dn_read_data", 32'(usb_data_o), 32'(i));
      usb_rd_n = 1'b0;
      step();
    end
    chk("rxf_after_last_pop", 32'(usb_rxf_n), 32'h1);
    usb_rd_n = 1'b1;
    step();
    chk("be_o_after_drain", 32'(usb_be_o), 32'h0);
    usb_oe_n = 1'b1;
    step();

    // UP fill to overflow with host stalled, then drain
    for (int i = 0; i < 17; i++) begin
      usb_wr_n = 1'b0; usb_be_i = 2'($urandom_range(1, 3)); usb_data_i = 16'($urandom);
      step();
      if (i == 12) chk("txe_n_at_13", 32'(usb_txe_n), 32'h0);
      if (i == 13) chk("txe_n_at_14", 32'(usb_txe_n), 32'h1);
    end
    chk("overflow_on_17th", 32'(wr_overflow), 32'h1);
    usb_wr_n = 1'b1; usb_be_i = 2'b00;
    h_m_tready = 1'b1;
    for (int i = 0; i < 17; i++) step();
    chk("up_drained", 32'(h_m_tvalid), 32'h0);
    h_m_tready = 1'b0;
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;

    // Concurrent push/pop on DN
    for (int i = 0; i < 3; i++) begin
      h_s_tvalid = 1'b1; h_s_tkeep = 2'($urandom_range(1, 3)); h_s_tdata = 16'($urandom);
      step();
    end
    usb_oe_n = 1'b0;
    for (int i = 0; i < 33; i++) begin
      usb_rd_n = (i == 0) ? 1'b1 : 1'b0;
      h_s_tkeep = 2'($urandom_range(1, 3)); h_s_tdata = 16'($urandom);
      step();
    end
    h_s_tvalid = 1'b0;
    for (int i = 0; i < 8 && dn_q.size() != 0; i++) step();
    usb_rd_n = 1'b1; usb_oe_n = 1'b1;
    step();

    // Concurrent push/pop on UP
    for (int i = 0; i < 35; i++) begin
      usb_wr_n = 1'b0; usb_be_i = 2'($urandom_range(1, 3)); usb_data_i = 16'($urandom);
      h_m_tready = (i >= 3) ? 1'b1 : 1'b0;
      step();
    end
    chk("no_flags_concurrent", 32'({wr_overflow, rd_underflow, proto_err}), 32'h0);
    usb_wr_n = 1'b1; usb_be_i = 2'b00;
    for (int i = 0; i < 4; i++) step();
    h_m_tready = 1'b0;

    // Protocol violations and clear
    usb_oe_n = 1'b0;
    step();
    usb_wr_n = 1'b0; usb_be_i = 2'b11; usb_data_i = 16'hBEEF;
    step();
    chk("proto_wr_oe", 32'(proto_err), 32'h1);
    chk("proto_up_unchanged", 32'(h_m_tvalid), 32'h0);
    usb_wr_n = 1'b1;
    usb_rd_n = 1'b0;
    step();
    chk("underflow_empty_rd", 32'(rd_underflow), 32'h1);
    usb_rd_n = 1'b1; usb_oe_n = 1'b1;
    clr_err = 1'b1;
    step();
    chk("flags_cleared", 32'({rd_underflow, proto_err}), 32'h0);
    clr_err = 1'b0;

    // Random traffic including violations and clears
    for (int i = 0; i < 400; i++) begin
      int mode;
      mode = $urandom_range(0, 9);
      usb_oe_n = 1'b1; usb_rd_n = 1'b1; usb_wr_n = 1'b1;
      if (mode <= 3) begin
        usb_oe_n = 1'b0; usb_rd_n = 1'($urandom);
      end else if (mode <= 7) begin
        usb_wr_n = 1'($urandom);
      end else if (mode == 8) begin
        usb_oe_n = 1'($urandom); usb_rd_n = 1'($urandom); usb_wr_n = 1'($urandom);
      end
      usb_be_i = 2'($urandom); usb_data_i = 16'($urandom);
      h_s_tvalid = 1'($urandom); h_s_tkeep = 2'($urandom); h_s_tdata = 16'($urandom);
      h_m_tready = 1'($urandom);
      clr_err = ($urandom_range(0, 15) == 0);
      step();
    end
    idle_inputs();
    step();

    // Reset in the middle of a read burst
    for (int i = 0; i < 10; i++) begin
      h_s_tvalid = 1'b1; h_s_tkeep = 2'b11; h_s_tdata = 16'($urandom);
      h_m_tready = 1'b1;
      step();
    end
    h_s_tvalid = 1'b0; h_m_tready = 1'b0;
    usb_oe_n = 1'b0;
    step();
    usb_rd_n = 1'b0;
    while (dn_q.size() > 8) step();
    rstn_usbclk = 1'b0;
    #1;
    model_reset();
    check_regs();
    chk("reset_mid_h_m_tvalid", 32'(h_m_tvalid), 32'h0);
    idle_inputs();
    repeat (2) @(posedge usb_clk);
    #1;
    rstn_usbclk = 1'b1;
    step();
    usb_oe_n = 1'b0;
    step();
    usb_rd_n = 1'b0;
    step();
    chk("underflow_after_reset", 32'(rd_underflow), 32'h1);
    idle_inputs();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ftdi_245fifo_dev_model.md
Name: ftdi_245fifo_dev_model

Overview:
Synthesizable device-side emulator of the FT60x 245 synchronous FIFO bus. It is the responder end of the bus that the FPGA-side 245 FIFO driver masters. It drives usb_txe_n, usb_rxf_n and read data, and accepts usb_wr_n, usb_rd_n, usb_oe_n and write data. Host-side AXIS ports replace the USB link, so the block serves as a loopback target for simulation and for chip-less board bring-up.

Parameters:
FIFO_BUS_WIDTH, 2, bus width in bytes (data width = 8*FIFO_BUS_WIDTH)
DN_DEPTH, 16, host-to-FPGA buffer entries; power of 2, >= 4
UP_DEPTH, 16, FPGA-to-host buffer entries; power of 2, >= 4
TXE_MARGIN, 2, free UP entries at or below which usb_txe_n deasserts; range 1..UP_DEPTH-1

Ports:
usb_clk  in  1  bus clock
rstn_usbclk  in  1  asynchronous active-low reset
usb_txe_n  out  1  low = UP buffer can accept writes
usb_rxf_n  out  1  low = DN buffer holds data
usb_wr_n  in  1  FPGA write strobe, active low
usb_rd_n  in  1  FPGA read strobe, active low
usb_oe_n  in  1  FPGA output-enable request, active low
usb_be_i  in  FIFO_BUS_WIDTH  byte enables written by FPGA
usb_data_i  in  8*FIFO_BUS_WIDTH  data written by FPGA
usb_be_o  out  FIFO_BUS_WIDTH  byte enables driven to FPGA
usb_be_t  out  1  be tristate: 0 = drive, 1 = hi-Z
usb_data_o  out  8*FIFO_BUS_WIDTH  data driven to FPGA
usb_data_t  out  1  data tristate: 0 = drive, 1 = hi-Z
h_s_tdata  in  8*FIFO_BUS_WIDTH  host payload into DN buffer
h_s_tkeep  in  FIFO_BUS_WIDTH  host byte enables
h_s_tvalid  in  1  host AXIS valid
h_s_tready  out  1  DN buffer not full
h_m_tdata  out  8*FIFO_BUS_WIDTH  UP buffer head data
h_m_tkeep  out  FIFO_BUS_WIDTH  UP buffer head byte enables
h_m_tvalid  out  1  UP buffer not empty
h_m_tready  in  1  host AXIS ready
clr_err  in  1  synchronous clear of sticky flags
wr_overflow  out  1  sticky: write accepted while UP buffer full
rd_underflow  out  1  sticky: read strobe while DN buffer empty
proto_err  out  1  sticky: bus-protocol violation

Behaviour:
- Reset (async assert, sync deassert use): both buffers flushed; pointers and counts cleared.
  - usb_txe_n=1, usb_rxf_n=1, usb_data_t=1, usb_be_t=1, usb_be_o=0, usb_data_o=0.
  - h_s_tready=0, h_m_tvalid=0, all sticky flags=0.
  - Reset mid-transfer drops all buffered data. No partial word survives.
- h_s_tready is registered. It is 1 when DN count < DN_DEPTH, and becomes 1 on the first clock after reset release.
- DN buffer: push {h_s_tkeep, h_s_tdata} on h_s_tvalid & h_s_tready. A push with tkeep=0 is discarded.
- Read path:
  - usb_data_t and usb_be_t are registered copies of usb_oe_n, so the bus turns around 1 cycle after OE changes.
  - Pop condition: usb_rd_n=0 & usb_oe_n=0 & DN count != 0. One entry per cycle.
  - usb_data_o/usb_be_o are registered. In cycle n+1 they hold the DN head remaining after cycle n's pop/push.
  - When DN is empty, or oe_n was high in cycle n, usb_be_o=0 in cycle n+1 and usb_data_o holds its last value.
- usb_rxf_n is registered: next value = (DN count_next == 0). It deasserts on the same edge the last entry is popped.
- Write path:
  - Push {usb_be_i, usb_data_i} into UP when usb_wr_n=0 & usb_oe_n=1 & |usb_be_i & UP not full.
  - If UP is full, the word is dropped and wr_overflow is set.
  - A write with be=0 is ignored and raises no flag.
- usb_txe_n is registered: next value = (UP_DEPTH - UP count_next <= TXE_MARGIN). This absorbs the FPGA's registered wr_n lag of up to TXE_MARGIN words.
- proto_err is set, and the offending access is ignored, on any of:
  - usb_wr_n=0 & usb_oe_n=0;
  - usb_rd_n=0 & usb_oe_n=1;
  - usb_wr_n=0 & usb_rd_n=0.
- rd_underflow is set on usb_rd_n=0 & usb_oe_n=0 & DN empty.
- Sticky flags clear on clr_err=1. A new event in the same cycle wins: the flag stays 1.
- UP host side is first-word fall-through: h_m_tvalid = UP count != 0, head presented combinationally from storage. Pop on h_m_tvalid & h_m_tready.
- Each buffer supports a simultaneous push and pop in one cycle; count is unchanged and data order is preserved.
- Pointers are log2(DEPTH) bits and wrap naturally. Counts are log2(DEPTH)+1 bits.

Test Plan:
- Reset, then idle: txe_n=0, rxf_n=1, data_t=1, be_o=0, h_s_tready=1 one cycle after release.
- Host pushes 4 words 0x0001..0x0004 (tkeep=2'b11): rxf_n=0 one cycle after the first push. FPGA asserts oe_n, then rd_n for 4 cycles: data_o returns 0x0001..0x0004 with be_o=2'b11 in order, rxf_n=1 on the edge of the 4th pop, be_o=0 afterwards.
- FPGA writes 16 words with UP_DEPTH=16, TXE_MARGIN=2 and h_m_tready=0: txe_n=1 after the 14th accepted write. Words 15-16 are accepted, a 17th write sets wr_overflow, and h_m drains exactly 16 words in order.
- Simultaneous: host pushes DN while FPGA reads DN, and FPGA writes UP while host drains UP, for 32 cycles at depth 16: no flags set, counts stable, all data matches.
- Protocol: wr_n=0 with oe_n=0 -> proto_err=1 and UP count unchanged. rd_n=0 with DN empty -> rd_underflow=1. clr_err pulse -> both flags 0.
- Reset asserted mid-read with 8 entries queued: rxf_n=1, be_o=0, data_t=1 immediately. After release DN is empty and a read sets rd_underflow.
